// File: rtl/gf_reduce_pkg.sv
// Shared definitions for the GF(2^m) arithmetic blocks: default field degree
// and the reducer's state encodings.
package gf_reduce_pkg;

    localparam int GF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_reduce.sv
// Sequential GF(2^m) reducer: folds a 2m-bit carry-less product modulo
// {1,poly}, one high bit per cycle, from x^(2m-1) down to x^m.
module gf_reduce
    import gf_reduce_pkg::*;
#(
    parameter int DATA_WIDTH = GF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*DATA_WIDTH-1:0]   in_prod,
    input  logic [DATA_WIDTH-1:0]     in_poly,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(PW);
    localparam logic [CW-1:0] IDX_TOP  = CW'(PW - 1);
    localparam logic [CW-1:0] IDX_LAST = CW'(DATA_WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE, out_valid only in DONE, so a result
    // handshake and a new acceptance can never share an edge.

    gf_state_e             state;
    logic [PW-1:0]         rem;
    logic [PW-1:0]         rem_next;
    logic [PW-1:0]         mask;
    logic [DATA_WIDTH-1:0] poly;
    logic [CW-1:0]         idx;

    // Full modulus aligned so its leading 1 sits on bit idx.
    always_comb begin
        mask     = {{(DATA_WIDTH-1){1'b0}}, 1'b1, poly} << (idx - IDX_LAST);
        rem_next = rem;
        if (rem[idx]) begin
            rem_next = rem ^ mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            poly  <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem   <= in_prod;
                        poly  <= in_poly;
                        idx   <= IDX_TOP;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    rem <= rem_next;
                    idx <= idx - 1'b1;
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_result = out_valid ? rem[DATA_WIDTH-1:0] : '0;

endmodule

// File: doc/gf_reduce.md
GF_REDUCE -- requirements
Module: gf_reduce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the field degree m of GF(2^m).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  the upstream multiplier's product is presented.
REQ-005 SHALL have port in_ready  output  1  the block can accept a product.
REQ-006 SHALL have port in_prod  input  2*DATA_WIDTH  the carry-less (polynomial) product; bit k is the coefficient of x^k.
REQ-007 SHALL have port in_poly  input  DATA_WIDTH  the reduction polynomial's low coefficients, with the x^DATA_WIDTH term implicit 1.
REQ-008 SHALL have port out_valid  output  1  out_result holds a reduced field element.
REQ-009 SHALL have port out_ready  input  1  the downstream stage accepts out_result.
REQ-010 SHALL have port out_result  output  DATA_WIDTH  in_prod mod ({1,in_poly}).

Function
REQ-011 SHALL implement states IDLE, REDUCE, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-012 SHALL, in IDLE on in_valid&&in_ready, latch in_prod into remainder R, latch in_poly, set bit index i = 2*DATA_WIDTH-1 and enter REDUCE.
REQ-013 SHALL, in each REDUCE cycle, XOR ({1,poly} << (i-DATA_WIDTH)) into R when R[i]=1, leave R unchanged otherwise, then decrement i.
REQ-014 SHALL enter DONE on the edge processing i=DATA_WIDTH, so REDUCE lasts exactly DATA_WIDTH cycles and out_valid rises DATA_WIDTH edges after the acceptance edge.
REQ-015 SHALL drive out_result = R[DATA_WIDTH-1:0], held stable throughout DONE regardless of in_* activity.
REQ-016 SHALL remain in DONE while out_ready=0 and go to IDLE on the edge where out_valid&&out_ready.
REQ-017 SHALL not accept a new product on the out_valid&&out_ready edge; the next acceptance is at the earliest one edge later.
REQ-018 SHALL ignore in_prod, in_poly and in_valid outside IDLE; changes after acceptance do not affect the result.
REQ-019 SHALL pass a product with no bits at or above x^DATA_WIDTH through unchanged, still taking DATA_WIDTH cycles.
REQ-020 SHALL use only XOR (no carries) on R; R width is 2*DATA_WIDTH, counter width is clog2(2*DATA_WIDTH).
REQ-021 SHALL drive out_result=0 in IDLE.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IDLE, R=0, latched poly=0, i=0: in_ready=1, out_valid=0, out_result=0.
REQ-023 SHALL abort any REDUCE or DONE operation on rst assertion without producing out_valid; the first product after release starts a fresh reduction.

Structure
REQ-024 SHALL place state encodings (IDLE/REDUCE/DONE) and the default DATA_WIDTH in the shared GF package/header used by the GF blocks.
REQ-025 SHALL be a single module with no sub-modules; the counter and shift-XOR datapath are inline.

Verification (DATA_WIDTH=8, in_poly=8'h1B, AES field)
REQ-026 SHALL check: in_prod=16'h2B79 (0x57*0x83 carry-less) -> out_result=8'hC1, out_valid exactly 8 edges after acceptance.
REQ-027 SHALL check: in_prod=16'h00A5 -> 8'hA5; in_prod=16'h0100 -> 8'h1B; in_prod=16'h8000 -> 8'h2F.
REQ-028 SHALL check backpressure: out_ready low 5 cycles in DONE -> out_result stays 8'hC1, in_ready stays 0, in_prod changes ignored.
REQ-029 SHALL check reset mid-REDUCE (cycle 4) -> out_valid never asserts, in_ready=1 and out_result=0 immediately; next product 16'h2B79 -> 8'hC1.
REQ-030 SHALL check back-to-back: in_valid held high with 50 random products -> each result matches a software GF(2^8) reference, one accept per IDLE visit.
